// File: rtl/histo_multilane_stream.sv
// histo_multilane_stream: multi-lane pixel histogram with streamed, lane-summed readout.
// Each clock, LANES pixels are binned into per-lane 2^PIX_W-entry counter RAMs while a frame
// is active. After the frame ends, every bin is streamed out in order as the sum of the lane
// counts. Each bin is cleared when its word is accepted.
// Ports:
//   clk, reset_n            clock, async active-low reset
//   pixel_data              LANES packed pixels, lane k at [k*PIX_W +: PIX_W]
//   frame_valid/line_valid  envelopes; a pixel counts when both are high
//   out_data/out_valid/out_ready/out_last  readout word stream (last = bin 2^PIX_W-1)
//   busy                    high in INIT/FLUSH/READ
//   frames_dropped          saturating count of frame starts seen while not IDLE
//   state_o                 current FSM state (debug)
// Optional macro HISTO_SATURATE_EN: lane counters saturate instead of wrapping.
module histo_multilane_stream #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned PIX_W  = 10,
  parameter int unsigned CNT_W  = 24,
  parameter int unsigned WORD_W = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [LANES*PIX_W-1:0] pixel_data,
  input  logic                   frame_valid,
  input  logic                   line_valid,
  output logic [WORD_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic [15:0]            frames_dropped,
  output logic [2:0]             state_o
);
  localparam int unsigned BINS = 1 << PIX_W;
  localparam logic [PIX_W-1:0] LAST_BIN = {PIX_W{1'b1}};

  if (WORD_W < CNT_W + $clog2(LANES)) begin : g_word_w_check
    $error("WORD_W must be >= CNT_W + clog2(LANES)");
  end

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_ACCUM = 3'd2,
    ST_FLUSH = 3'd3,
    ST_READ  = 3'd4
  } state_t;

  state_t                        state, state_d;
  logic [PIX_W-1:0]              bin, bin_d, out_bin;
  logic [1:0]                    flush_cnt, flush_d;
  logic                          issued, issued_d;
  logic                          fv_q, rise, accept, pix_en, load;
  logic [LANES-1:0][PIX_W-1:0]   lane_pix, s1_a, s2_a, s3_a, wa, ra;
  logic [LANES-1:0][CNT_W-1:0]   rd_q, fwd, inc, s2_d, s3_d, wd;
  logic [LANES-1:0]              we;
  logic                          s1_v, s2_v, s3_v;
  logic [WORD_W-1:0]             lane_sum;
  logic [CNT_W-1:0]              mem [LANES][BINS];

  assign rise    = frame_valid & ~fv_q;
  assign accept  = out_valid & out_ready;
  assign pix_en  = frame_valid & line_valid &
                   ((state == ST_ACCUM) | ((state == ST_IDLE) & rise));
  assign state_o = state;

  // Next-state and control decode
  always_comb begin
    state_d  = state;
    bin_d    = bin;
    flush_d  = '0;
    issued_d = issued;
    load     = 1'b0;
    case (state)
      ST_INIT: begin
        bin_d = bin + PIX_W'(1);
        if (bin == LAST_BIN) state_d = ST_IDLE;
      end
      ST_IDLE:  if (rise) state_d = ST_ACCUM;
      ST_ACCUM: if (!frame_valid) state_d = ST_FLUSH;
      ST_FLUSH: begin
        flush_d = flush_cnt + 2'd1;
        if (flush_cnt == 2'd2) state_d = ST_READ;
      end
      ST_READ: begin
        // rd_q always holds the bin addressed by 'bin'; refill the output slot when it frees
        if (!issued && (!out_valid || accept)) begin
          load  = 1'b1;
          bin_d = bin + PIX_W'(1);
          if (bin == LAST_BIN) issued_d = 1'b1;
        end
        if (accept && out_last) begin
          state_d  = ST_IDLE;
          issued_d = 1'b0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Lane split, read-modify-write forwarding and lane sum
  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_pix[k] = pixel_data[k*PIX_W +: PIX_W];
      // s2 is written at the end of this cycle, s3 was written on the same edge rd_q sampled
      if (s2_v && (s2_a[k] == s1_a[k]))      fwd[k] = s2_d[k];
      else if (s3_v && (s3_a[k] == s1_a[k])) fwd[k] = s3_d[k];
      else                                   fwd[k] = rd_q[k];
`ifdef HISTO_SATURATE_EN
      inc[k] = (&fwd[k]) ? fwd[k] : fwd[k] + CNT_W'(1);
`else
      inc[k] = fwd[k] + CNT_W'(1);
`endif
      lane_sum = lane_sum + WORD_W'(rd_q[k]);
      if (state == ST_INIT) begin
        we[k] = 1'b1;
        wa[k] = bin;
        wd[k] = '0;
      end else if (state == ST_READ) begin
        we[k] = accept;
        wa[k] = out_bin;
        wd[k] = '0;
      end else begin
        we[k] = s2_v;
        wa[k] = s2_a[k];
        wd[k] = s2_d[k];
      end
      ra[k] = ((state == ST_IDLE) || (state == ST_ACCUM)) ? lane_pix[k] : bin_d;
    end
  end

  // Per-lane counter RAMs (not reset)
  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (we[k]) mem[k][wa[k]] <= wd[k];
      rd_q[k] <= mem[k][ra[k]];
    end
  end

  // State, pipeline and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_INIT;
      bin            <= '0;
      flush_cnt      <= '0;
      issued         <= 1'b0;
      fv_q           <= 1'b1;
      out_data       <= '0;
      out_valid      <= 1'b0;
      out_last       <= 1'b0;
      out_bin        <= '0;
      busy           <= 1'b1;
      frames_dropped <= '0;
      s1_v           <= 1'b0;
      s2_v           <= 1'b0;
      s3_v           <= 1'b0;
      s1_a           <= '0;
      s2_a           <= '0;
      s3_a           <= '0;
      s2_d           <= '0;
      s3_d           <= '0;
    end else begin
      state     <= state_d;
      bin       <= bin_d;
      flush_cnt <= flush_d;
      issued    <= issued_d;
      fv_q      <= frame_valid;
      busy      <= (state_d == ST_INIT) || (state_d == ST_FLUSH) || (state_d == ST_READ);
      if (rise && (state != ST_IDLE) && (frames_dropped != 16'hFFFF))
        frames_dropped <= frames_dropped + 16'd1;
      s1_v <= pix_en;
      s1_a <= lane_pix;
      s2_v <= s1_v;
      s2_a <= s1_a;
      s2_d <= inc;
      s3_v <= s2_v;
      s3_a <= s2_a;
      s3_d <= s2_d;
      if (load) begin
        out_data  <= lane_sum;
        out_last  <= (bin == LAST_BIN);
        out_valid <= 1'b1;
        out_bin   <= bin;
      end else if (accept) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_histo_multilane_stream.sv
`timescale 1ns/1ps
module tb_histo_multilane_stream;
  localparam int unsigned LANES = 2, PIX_W = 10, CNT_W = 24, WORD_W = 32, BINS = 1024;
  localparam int unsigned P2 = 4, C2 = 4, W2 = 8, B2 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset_n;
  logic [LANES*PIX_W-1:0] pixel_data;
  logic                   frame_valid, line_valid;
  logic [WORD_W-1:0]      out_data;
  logic                   out_valid, out_ready, out_last, busy;
  logic [15:0]            frames_dropped;
  logic [2:0]             state_o;

  logic [2*P2-1:0]        d2_pix;
  logic                   d2_fv, d2_lv, d2_valid, d2_ready, d2_last, d2_busy;
  logic [W2-1:0]          d2_data;
  logic [15:0]            d2_drop;
  logic [2:0]             d2_state;

  histo_multilane_stream #(.LANES(LANES), .PIX_W(PIX_W), .CNT_W(CNT_W), .WORD_W(WORD_W)) dut (
    .clk(clk), .reset_n(reset_n), .pixel_data(pixel_data), .frame_valid(frame_valid),
    .line_valid(line_valid), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .frames_dropped(frames_dropped), .state_o(state_o));

  histo_multilane_stream #(.LANES(2), .PIX_W(P2), .CNT_W(C2), .WORD_W(W2)) dut2 (
    .clk(clk), .reset_n(reset_n), .pixel_data(d2_pix), .frame_valid(d2_fv),
    .line_valid(d2_lv), .out_data(d2_data), .out_valid(d2_valid), .out_ready(d2_ready),
    .out_last(d2_last), .busy(d2_busy), .frames_dropped(d2_drop), .state_o(d2_state));

  typedef struct packed { logic [31:0] data; logic last; } exp_t;
  exp_t q[$];
  exp_t q2[$];

  int vectors = 0;
  int miscompares = 0;
  int acc_cnt = 0;
  int exp_drops = 0;
  bit rdy_mode = 1'b0;
  int unsigned hist [LANES][BINS];
  int unsigned hist2 [2][B2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference lane counter value after 'hits' increments in a cw-bit counter
  function automatic longint unsigned lane_val(input int unsigned hits, input int cw);
    longint unsigned m;
    m = (64'd1 << cw) - 64'd1;
`ifdef HISTO_SATURATE_EN
    return (64'(hits) > m) ? m : 64'(hits);
`else
    return 64'(hits) % (m + 64'd1);
`endif
  endfunction

  function automatic int unsigned pix_val(input int mode, input int k, input int i);
    case (mode)
      0:       return 5;
      1:       return (k == 0) ? i : 1023 - i;
      2:       return $urandom_range(0, 7);
      default: return $urandom_range(0, 1023);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Convert the accumulated model histogram into expected words and clear it
  task automatic push_frame();
    exp_t e;
    longint unsigned s;
    for (int b = 0; b < BINS; b++) begin
      s = 0;
      for (int k = 0; k < LANES; k++) begin
        s += lane_val(hist[k][b], CNT_W);
        hist[k][b] = 0;
      end
      e.data = 32'(s);
      e.last = (b == BINS - 1);
      q.push_back(e);
    end
  endtask

  task automatic send_frame(input int nlines, input int nclk, input int mode, input int lead);
    int unsigned v;
    frame_valid = 1'b1;
    line_valid  = 1'b0;
    pixel_data  = (LANES*PIX_W)'($urandom);
    repeat (lead) tick();
    for (int l = 0; l < nlines; l++) begin
      for (int i = 0; i < nclk; i++) begin
        line_valid = 1'b1;
        for (int k = 0; k < LANES; k++) begin
          v = pix_val(mode, k, i);
          pixel_data[k*PIX_W +: PIX_W] = PIX_W'(v);
          hist[k][v]++;
        end
        tick();
      end
      if (l != nlines - 1) begin
        line_valid = 1'b0;
        pixel_data = (LANES*PIX_W)'($urandom);
        repeat (2) tick();
      end
    end
    // frame_valid falls right after the last pixel
    frame_valid = 1'b0;
    line_valid  = 1'b0;
    pixel_data  = (LANES*PIX_W)'($urandom);
    push_frame();
    tick();
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 12000) begin
      tick();
      n++;
    end
    check(name, 64'(n < 12000), 64'd1);
  endtask

  task automatic wait_accepts(input int cnt);
    int n, base;
    n = 0;
    base = acc_cnt;
    while (acc_cnt < base + cnt && n < 8000) begin
      tick();
      n++;
    end
    check("accept_wait_timeout", 64'(n < 8000), 64'd1);
  endtask

  task automatic measure_init(input string name);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    check(name, 64'(n), 64'd1024);
  endtask

  // Ready driver
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor / scoreboard for the main instance
  logic              prev_stall = 1'b0;
  logic [WORD_W-1:0] prev_data  = '0;
  logic              prev_last  = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", 64'({out_valid, out_last, out_data}), 64'({1'b1, prev_last, prev_data}));
      if (out_valid && out_ready) begin
        acc_cnt++;
        if (q.size() == 0) begin
          check("unexpected_word", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = q.pop_front();
          check("word_data", 64'(out_data), 64'(e.data));
          check("word_last", 64'(out_last), 64'(e.last));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  // Monitor / scoreboard for the narrow-counter instance
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && d2_valid && d2_ready) begin
      if (q2.size() == 0) begin
        check("d2_unexpected_word", 64'(d2_data), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = q2.pop_front();
        check("d2_word_data", 64'(d2_data), 64'(e.data));
        check("d2_word_last", 64'(d2_last), 64'(e.last));
      end
    end
  end

  initial begin
    #(80000 * 10);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    longint unsigned s;
    int n;
    reset_n = 1'b0;
    pixel_data = '0;
    frame_valid = 1'b0;
    line_valid = 1'b0;
    d2_pix = '0;
    d2_fv = 1'b0;
    d2_lv = 1'b0;
    d2_ready = 1'b1;
    for (int k = 0; k < LANES; k++)
      for (int b = 0; b < BINS; b++) hist[k][b] = 0;
    for (int k = 0; k < 2; k++)
      for (int b = 0; b < B2; b++) hist2[k][b] = 0;
    repeat (3) tick();

    // Reset values
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_frames_dropped", 64'(frames_dropped), 64'd0);
    reset_n = 1'b1;
    measure_init("init_busy_cycles");

    // Empty frame: fv pulse, lv low -> all-zero histogram
    frame_valid = 1'b1;
    pixel_data  = (LANES*PIX_W)'($urandom);
    repeat (4) tick();
    frame_valid = 1'b0;
    push_frame();
    wait_drain("drain_empty_frame");

    // Same-bin hits back to back
    send_frame(4, 8, 0, 2);
    wait_drain("drain_bin5_frame");

    // Ramp across all bins, twice (second frame sees cleared RAM)
    send_frame(1, 1024, 1, 1);
    wait_drain("drain_ramp1");
    send_frame(1, 1024, 1, 0);
    wait_drain("drain_ramp2");

    // Random backpressure with random and collision-heavy pixels
    rdy_mode = 1'b1;
    send_frame(3, 50, 3, 1);
    wait_drain("drain_rand_full");
    send_frame(2, 40, 2, 0);
    wait_drain("drain_rand_collide");

    // Frame start during readout is dropped and does not disturb the words
    send_frame(4, 8, 0, 2);
    wait_accepts(100);
    frame_valid = 1'b1;
    line_valid  = 1'b1;
    pixel_data  = (LANES*PIX_W)'($urandom);
    repeat (3) tick();
    frame_valid = 1'b0;
    line_valid  = 1'b0;
    exp_drops   = 1;
    wait_drain("drain_drop_frame");
    check("frames_dropped_after_read_rise", 64'(frames_dropped), 64'(exp_drops));
    send_frame(2, 16, 2, 1);
    wait_drain("drain_after_drop");
    check("frames_dropped_stable", 64'(frames_dropped), 64'(exp_drops));
    rdy_mode = 1'b0;

    // Reset in the middle of readout
    send_frame(2, 30, 3, 1);
    wait_accepts(300);
    reset_n = 1'b0;
    #1;
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_busy", 64'(busy), 64'd1);
    check("midreset_out_data", 64'(out_data), 64'd0);
    check("midreset_frames_dropped", 64'(frames_dropped), 64'd0);
    q.delete();
    q2.delete();
    exp_drops = 0;
    repeat (2) tick();
    reset_n = 1'b1;
    measure_init("reinit_busy_cycles");
    send_frame(2, 20, 2, 0);
    wait_drain("drain_after_reset");

    // Narrow counters: 20 hits on bin 3 in lane 0
    d2_fv = 1'b1;
    d2_lv = 1'b1;
    for (int i = 0; i < 20; i++) begin
      n = (i % 2 == 1) ? 7 : 12;
      d2_pix = {4'(n), 4'd3};
      hist2[0][3]++;
      hist2[1][n]++;
      tick();
    end
    d2_fv = 1'b0;
    d2_lv = 1'b0;
    for (int b = 0; b < B2; b++) begin
      s = lane_val(hist2[0][b], C2) + lane_val(hist2[1][b], C2);
      e.data = 32'(s);
      e.last = (b == B2 - 1);
      q2.push_back(e);
    end
    n = 0;
    while ((q2.size() != 0 || d2_busy) && n < 2000) begin
      tick();
      n++;
    end
    check("d2_drain", 64'(n < 2000), 64'd1);

    check("final_queue_empty", 64'(q.size()), 64'd0);
    check("final_frames_dropped", 64'(frames_dropped), 64'(exp_drops));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
